// File: rtl/store_data_aligner_pkg.sv
// rtl/store_data_aligner_pkg.sv - shared size codes, FSM states and buffer entry layout
package store_data_aligner_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Address is kept word-aligned with the low two bits zeroed.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/store_data_aligner_store_fifo.sv
// rtl/store_data_aligner_store_fifo.sv - DEPTH-entry synchronous FIFO holding formatted stores
module store_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 68
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/store_data_aligner.sv
// rtl/store_data_aligner.sv - formats stores into byte lanes, buffers them, drives the memory write port
module store_data_aligner
    import store_data_aligner_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        misalign_err,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    state_e          state;
    state_e          next_state;
    entry_t          head;
    entry_t          push_entry;
    logic [31:0]     fmt_wdata;
    logic [3:0]      fmt_be;
    logic            legal;
    logic            accept;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;

    assign in_ready = ~full;
    assign accept   = in_valid & in_ready;
    assign push     = accept & legal;
    assign pop      = (state == ST_REQ) & mem_ack;

    // Big-endian lanes: lane 3 (bits 31:24) is byte offset 0.
    always_comb begin
        fmt_wdata = in_data;
        fmt_be    = 4'b1111;
        legal     = 1'b1;
        case (size_e'(in_size))
            SZ_BYTE: begin
                fmt_wdata = {4{in_data[7:0]}};
                fmt_be    = 4'b1000 >> in_addr[1:0];
            end
            SZ_HALF: begin
                fmt_wdata = {2{in_data[15:0]}};
                fmt_be    = in_addr[1] ? 4'b0011 : 4'b1100;
                legal     = ~in_addr[0];
            end
            SZ_WORD: legal = (in_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign push_entry = '{addr: {in_addr[31:2], 2'b00}, wdata: fmt_wdata, be: fmt_be};

    store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_entry),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Leave REQ only when the last entry is acked with nothing arriving behind it.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (!empty) next_state = ST_REQ;
            ST_REQ:  if (mem_ack && count == ONE_CNT && !push) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (state == ST_REQ) begin
            mem_req   = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.wdata;
            mem_be    = head.be;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) misalign_err <= 1'b0;
        else          misalign_err <= accept & ~legal;
    end

    assign busy = (count != '0) | mem_req;

endmodule

// File: tb/tb_store_data_aligner.sv
// tb/tb_store_data_aligner.sv - directed and randomized checks against a queue-based store model
module tb_store_data_aligner;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_size = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        misalign_err;
    logic        busy;

    store_data_aligner #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_size      (in_size),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .misalign_err (misalign_err),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t  q[$];
    logic m_req = 1'b0;
    logic m_err = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_writes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic wr_t fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        wr_t w;
        w.addr = a & 32'hFFFF_FFFC;
        case (s)
            2'd0: begin
                w.data = (d & 32'hFF) * 32'h0101_0101;
                w.be   = 4'(8 >> (a % 4));
            end
            2'd1: begin
                w.data = (d & 32'hFFFF) * 32'h0001_0001;
                w.be   = ((a / 2) % 2 == 1) ? 4'b0011 : 4'b1100;
            end
            default: begin
                w.data = d;
                w.be   = 4'b1111;
            end
        endcase
        return w;
    endfunction

    function automatic bit is_legal(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1'b0;
        if (s == 2'd1) return (a % 2) == 0;
        if (s == 2'd2) return (a % 4) == 0;
        return 1'b1;
    endfunction

    // One clock: check outputs at the falling edge, drive inputs, advance the model over the next rising edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic ack, output bit acc);
        int  sz;
        bit  popped;
        @(negedge clock);
        sz = q.size();
        check("in_ready", in_ready, sz < DEPTH);
        check("mem_req", mem_req, m_req);
        check("busy", busy, (sz != 0) || m_req);
        check("misalign_err", misalign_err, m_err);
        if (m_req) begin
            check("mem_addr", mem_addr, q[0].addr);
            check("mem_wdata", mem_wdata, q[0].data);
            check("mem_be", mem_be, q[0].be);
        end
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        in_size  = s;
        mem_ack  = ack;
        acc    = v && (sz < DEPTH);
        popped = m_req && ack;
        if (popped) begin
            void'(q.pop_front());
            n_writes++;
        end
        if (acc && is_legal(a, s)) q.push_back(fmt(a, d, s));
        m_err = acc && !is_legal(a, s);
        m_req = m_req ? (q.size() != 0) : (sz != 0);
    endtask

    task automatic idle(input int n, input logic ack);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, 2'($urandom), ack, acc);
    endtask

    initial begin
        bit acc;
        bit done;
        #12;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_misalign", misalign_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        // Word store, ack in the second request cycle.
        cycle(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, acc);
        idle(1, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        check("t1_writes", n_writes, 1);

        // Two bytes, ordered.
        cycle(1'b1, 32'h203, 32'h0000_00A5, 2'd0, 1'b1, acc);
        cycle(1'b1, 32'h200, 32'h0000_005A, 2'd0, 1'b1, acc);
        idle(5, 1'b1);

        // Aligned half, then misaligned half.
        cycle(1'b1, 32'h302, 32'h0000_1234, 2'd1, 1'b1, acc);
        idle(4, 1'b1);
        cycle(1'b1, 32'h301, 32'h0000_1234, 2'd1, 1'b1, acc);
        idle(3, 1'b1);
        check("t3_writes", n_writes, 4);

        // Fill with ack held low, then drain while the third store waits.
        cycle(1'b1, 32'h400, 32'h1111_1111, 2'd2, 1'b0, acc);
        cycle(1'b1, 32'h404, 32'h2222_2222, 2'd2, 1'b0, acc);
        done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h408, 32'h3333_3333, 2'd2, 1'b0, acc);
            check("t4_blocked", acc, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(!done, 32'h408, 32'h3333_3333, 2'd2, 1'b1, acc);
            done = done | acc;
        end
        check("t4_third_accepted", done, 1'b1);
        check("t4_writes", n_writes, 7);

        // Enqueue in the same cycle the single buffered entry is acked.
        cycle(1'b1, 32'h500, 32'hAAAA_0001, 2'd2, 1'b0, acc);
        idle(1, 1'b0);
        cycle(1'b1, 32'h504, 32'hAAAA_0002, 2'd2, 1'b1, acc);
        idle(4, 1'b1);
        check("t5_writes", n_writes, 9);

        // Reset while requesting with two entries buffered.
        cycle(1'b1, 32'h600, 32'h6666_0000, 2'd2, 1'b0, acc);
        cycle(1'b1, 32'h604, 32'h6666_0004, 2'd2, 1'b0, acc);
        idle(2, 1'b0);
        @(negedge clock);
        check("t6_pre_req", mem_req, 1'b1);
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t6_req_drop", mem_req, 1'b0);
        check("t6_busy_drop", busy, 1'b0);
        check("t6_ready", in_ready, 1'b1);
        q.delete();
        m_req = 1'b0;
        m_err = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mem_ack = 1'b1;
        idle(6, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = {20'h0, 10'($urandom), 2'($urandom)};
            cycle(($urandom % 10) < 6, a, $urandom, 2'($urandom), ($urandom % 2) == 1, acc);
        end
        idle(8, 1'b1);
        check("final_empty", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
